// File: rtl/sw_alloc_vc.sv
// rtl/sw_alloc_vc.sv - per-(output port, output VC) round-robin switch allocator with credit tracking
module sw_alloc_vc #(
  parameter int NUM_PORTS    = 5,
  parameter int NUM_VCS      = 4,
  parameter int VC_ID_BITS   = $clog2(NUM_VCS),
  parameter int CREDIT_DEPTH = 4,
  parameter int CNT_BITS     = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid [NUM_PORTS][NUM_VCS],
  input  logic [2:0]            req_port  [NUM_PORTS][NUM_VCS],
  input  logic [VC_ID_BITS-1:0] req_vc    [NUM_PORTS][NUM_VCS],
  input  logic                  credit_in [NUM_PORTS][NUM_VCS],
  output logic                  grant     [NUM_PORTS][NUM_VCS],
  output logic                  out_valid [NUM_PORTS][NUM_VCS],
  output logic [1:0]            p_sel     [NUM_PORTS][NUM_VCS],
  output logic [VC_ID_BITS-1:0] vc_sel    [NUM_PORTS][NUM_VCS],
  output logic                  credit_err
);

  localparam int N        = NUM_PORTS * NUM_VCS;
  localparam int IDX_BITS = $clog2(N);

  logic [IDX_BITS-1:0]   ptr_q     [NUM_PORTS][NUM_VCS];
  logic [IDX_BITS-1:0]   ptr_d     [NUM_PORTS][NUM_VCS];
  logic [CNT_BITS-1:0]   credit_q  [NUM_PORTS][NUM_VCS];
  logic [CNT_BITS-1:0]   credit_d  [NUM_PORTS][NUM_VCS];
  logic                  grant_d   [NUM_PORTS][NUM_VCS];
  logic                  ov_d      [NUM_PORTS][NUM_VCS];
  logic [1:0]            psel_d    [NUM_PORTS][NUM_VCS];
  logic [VC_ID_BITS-1:0] vsel_d    [NUM_PORTS][NUM_VCS];
  logic                  err_d;

  // Per-lane arbitration: two passes give a rotating priority starting at ptr
  // (first pass covers candidates >= ptr, second wraps around to the rest).
  // The lane's credit counter is updated in the same step.
  always_comb begin
    logic found;
    logic elig;
    int   k;
    for (int ip = 0; ip < NUM_PORTS; ip++) begin
      for (int iv = 0; iv < NUM_VCS; iv++) begin
        grant_d[ip][iv] = 1'b0;
      end
    end
    err_d = credit_err;
    found = 1'b0;
    elig  = 1'b0;
    k     = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        ov_d[p][v]     = 1'b0;
        psel_d[p][v]   = '0;
        vsel_d[p][v]   = '0;
        ptr_d[p][v]    = ptr_q[p][v];
        credit_d[p][v] = credit_q[p][v];
        found          = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
          for (int ip = 0; ip < NUM_PORTS; ip++) begin
            for (int iv = 0; iv < NUM_VCS; iv++) begin
              k    = ip * NUM_VCS + iv;
              // a self-port request is dropped; a granted input is masked
              // because its req_valid still shows the flit being consumed
              elig = req_valid[ip][iv]
                     && (req_port[ip][iv] == 3'(p))
                     && (req_vc[ip][iv] == VC_ID_BITS'(v))
                     && (req_port[ip][iv] != 3'(ip))
                     && (credit_q[p][v] != '0)
                     && !grant[ip][iv];
              if (!found && elig && ((pass == 1) || (k >= int'(ptr_q[p][v])))) begin
                found           = 1'b1;
                grant_d[ip][iv] = 1'b1;
                ov_d[p][v]      = 1'b1;
                psel_d[p][v]    = (ip < p) ? 2'(ip) : 2'(ip - 1);
                vsel_d[p][v]    = VC_ID_BITS'(iv);
                ptr_d[p][v]     = IDX_BITS'((k + 1) % N);
              end
            end
          end
        end
        if (found && !credit_in[p][v]) begin
          credit_d[p][v] = credit_q[p][v] - 1'b1;
        end else if (!found && credit_in[p][v]) begin
          if (credit_q[p][v] == CNT_BITS'(CREDIT_DEPTH)) begin
            err_d = 1'b1;
          end else begin
            credit_d[p][v] = credit_q[p][v] + 1'b1;
          end
        end
      end
    end
  end

  // Register grants, crossbar selects, pointers, credit counters and the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          grant[p][v]     <= 1'b0;
          out_valid[p][v] <= 1'b0;
          p_sel[p][v]     <= '0;
          vc_sel[p][v]    <= '0;
          ptr_q[p][v]     <= '0;
          credit_q[p][v]  <= CNT_BITS'(CREDIT_DEPTH);
        end
      end
      credit_err <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          grant[p][v]     <= grant_d[p][v];
          out_valid[p][v] <= ov_d[p][v];
          p_sel[p][v]     <= psel_d[p][v];
          vc_sel[p][v]    <= vsel_d[p][v];
          ptr_q[p][v]     <= ptr_d[p][v];
          credit_q[p][v]  <= credit_d[p][v];
        end
      end
      credit_err <= err_d;
    end
  end

endmodule

// File: tb/tb_sw_alloc_vc.sv
// tb/tb_sw_alloc_vc.sv - self-checking bench for sw_alloc_vc
module tb_sw_alloc_vc;
  localparam int NP = 5;
  localparam int NV = 4;
  localparam int VB = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid [NP][NV];
  logic [2:0]    req_port  [NP][NV];
  logic [VB-1:0] req_vc    [NP][NV];
  logic          credit_in [NP][NV];
  logic          grant     [NP][NV];
  logic          out_valid [NP][NV];
  logic [1:0]    p_sel     [NP][NV];
  logic [VB-1:0] vc_sel    [NP][NV];
  logic          credit_err;

  sw_alloc_vc dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_port(req_port), .req_vc(req_vc),
    .credit_in(credit_in),
    .grant(grant), .out_valid(out_valid), .p_sel(p_sel), .vc_sel(vc_sel),
    .credit_err(credit_err)
  );

  // free-running clock
  always #5 clk = ~clk;

  typedef struct {
    int ip; int iv; int p; int v; int g; int psel; int vsel;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[6];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int a = 0; a < NP; a++) begin
      for (int b = 0; b < NV; b++) begin
        req_valid[a][b] = 1'b0;
        req_port[a][b]  = '0;
        req_vc[a][b]    = '0;
        credit_in[a][b] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int ip, input int iv, input int p, input int v);
    req_valid[ip][iv] = 1'b1;
    req_port[ip][iv]  = 3'(p);
    req_vc[ip][iv]    = VB'(v);
  endtask

  function automatic int activity();
    int n = 0;
    for (int a = 0; a < NP; a++) begin
      for (int b = 0; b < NV; b++) begin
        n += int'(grant[a][b]) + int'(out_valid[a][b]);
      end
    end
    return n;
  endfunction

  function automatic int stray_sel();
    int n = 0;
    for (int a = 0; a < NP; a++) begin
      for (int b = 0; b < NV; b++) begin
        if (!out_valid[a][b] && (p_sel[a][b] != 0 || vc_sel[a][b] != 0)) n++;
      end
    end
    return n;
  endfunction

  task automatic push_exp(input int ip, input int iv, input int p, input int v,
                          input int g, input int ps, input int vs);
    vec_t e;
    e.ip = ip; e.iv = iv; e.p = p; e.v = v; e.g = g; e.psel = ps; e.vsel = vs;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input string name);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty scoreboard expected one entry", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, " grant"}, int'(grant[e.ip][e.iv]), e.g);
      chk({name, " out_valid"}, int'(out_valid[e.p][e.v]), e.g);
      chk({name, " p_sel"}, int'(p_sel[e.p][e.v]), e.g ? e.psel : 0);
      chk({name, " vc_sel"}, int'(vc_sel[e.p][e.v]), e.g ? e.vsel : 0);
      chk({name, " activity"}, activity(), e.g ? 2 : 0);
      chk({name, " stray sel"}, stray_sel(), 0);
    end
  endtask

  // bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{ip:0, iv:1, p:2, v:3, g:1, psel:0, vsel:1};
    tbl[1] = '{ip:4, iv:0, p:1, v:0, g:1, psel:3, vsel:0};
    tbl[2] = '{ip:1, iv:2, p:3, v:0, g:1, psel:1, vsel:2};
    tbl[3] = '{ip:2, iv:0, p:2, v:1, g:0, psel:0, vsel:0};
    tbl[4] = '{ip:3, iv:3, p:0, v:2, g:1, psel:2, vsel:3};
    tbl[5] = '{ip:0, iv:0, p:4, v:3, g:1, psel:0, vsel:0};

    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset activity", activity(), 0);
    chk("reset stray sel", stray_sel(), 0);
    chk("reset credit_err", int'(credit_err), 0);
    rst_n = 1'b1;
    step();

    // single-cycle requests, one per vector
    for (int i = 0; i < 6; i++) begin
      set_req(tbl[i].ip, tbl[i].iv, tbl[i].p, tbl[i].v);
      push_exp(tbl[i].ip, tbl[i].iv, tbl[i].p, tbl[i].v, tbl[i].g, tbl[i].psel, tbl[i].vsel);
      step();
      clear_inputs();
      sb_check($sformatf("vec%0d", i));
      step();
      chk($sformatf("vec%0d idle", i), activity(), 0);
    end
    chk("credit 2,3 after one grant", int'(dut.credit_q[2][3]), 3);
    chk("credit 2,1 after illegal", int'(dut.credit_q[2][1]), 4);

    // round-robin between (0,0) and (3,2) on lane (2,1), credit returned each grant
    set_req(0, 0, 2, 1);
    set_req(3, 2, 2, 1);
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) push_exp(0, 0, 2, 1, 1, 0, 0);
      else            push_exp(3, 2, 2, 1, 1, 2, 2);
      step();
      credit_in[2][1] = 1'b1;
      sb_check($sformatf("rr%0d", c));
    end
    clear_inputs();
    step();
    chk("rr credit", int'(dut.credit_q[2][1]), 3);

    // credit exhaustion on lane (4,2) from input (1,0)
    set_req(1, 0, 4, 2);
    for (int c = 1; c <= 10; c++) begin
      push_exp(1, 0, 4, 2, ((c % 2 == 1) && (c <= 7)) ? 1 : 0, 1, 0);
      step();
      sb_check($sformatf("exh%0d", c));
    end
    chk("exh credit zero", int'(dut.credit_q[4][2]), 0);
    credit_in[4][2] = 1'b1;
    push_exp(1, 0, 4, 2, 0, 1, 0);
    step();
    credit_in[4][2] = 1'b0;
    sb_check("refill c11");
    push_exp(1, 0, 4, 2, 1, 1, 0);
    step();
    sb_check("refill c12");
    for (int c = 13; c <= 14; c++) begin
      push_exp(1, 0, 4, 2, 0, 1, 0);
      step();
      sb_check($sformatf("refill c%0d", c));
    end

    // credit arriving in the same cycle as a grant decision
    credit_in[4][2] = 1'b1;
    push_exp(1, 0, 4, 2, 0, 1, 0);
    step();
    sb_check("same c15");
    push_exp(1, 0, 4, 2, 1, 1, 0);
    step();
    sb_check("same c16");
    chk("same-cycle credit", int'(dut.credit_q[4][2]), 1);
    clear_inputs();
    step();

    // overflow into a full counter
    credit_in[4][2] = 1'b1;
    repeat (3) step();
    chk("full credit", int'(dut.credit_q[4][2]), 4);
    chk("credit_err before", int'(credit_err), 0);
    step();
    clear_inputs();
    chk("credit_err set", int'(credit_err), 1);
    chk("credit held at full", int'(dut.credit_q[4][2]), 4);
    repeat (3) step();
    chk("credit_err sticky", int'(credit_err), 1);

    // self-port request is never granted
    set_req(2, 0, 2, 3);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("illegal c%0d", c), activity(), 0);
    end
    clear_inputs();

    // reset while grants are flowing
    set_req(0, 0, 2, 1);
    set_req(3, 2, 2, 1);
    credit_in[2][1] = 1'b1;
    step();
    step();
    chk("flowing", activity(), 2);
    rst_n = 1'b0;
    #1;
    chk("async reset activity", activity(), 0);
    chk("async reset stray sel", stray_sel(), 0);
    chk("async reset credit_err", int'(credit_err), 0);
    clear_inputs();
    step();
    rst_n = 1'b1;
    chk("post reset credit", int'(dut.credit_q[2][3]), 4);
    chk("post reset ptr", int'(dut.ptr_q[2][1]), 0);
    set_req(0, 1, 2, 3);
    push_exp(0, 1, 2, 3, 1, 0, 1);
    step();
    clear_inputs();
    sb_check("post reset single");
    step();
    chk("post reset idle", activity(), 0);
    chk("post reset credit used", int'(dut.credit_q[2][3]), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_alloc_vc.md
Name: sw_alloc_vc

Overview:
- Per-(output port, output VC) switch allocator for the VC router.
- Collects head-flit requests from every input VC and tracks downstream credits per output VC.
- Grants one requester per output lane per cycle, round-robin.
- Drives the select buses consumed by the per-VC crossbar: p_sel is relative input-port index with the output's own port skipped; vc_sel is the input VC. It also returns registered grants to the input VCs.

Parameters:
- NUM_PORTS, 5 (router_pkg): router ports, including local.
- NUM_VCS, 4 (router_pkg): VCs per port.
- VC_ID_BITS, $clog2(NUM_VCS) (router_pkg): VC index width.
- CREDIT_DEPTH, 4: downstream buffer depth per VC; the credit counter reset value.
- CNT_BITS, $clog2(CREDIT_DEPTH+1): credit counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid [NUM_PORTS][NUM_VCS]  in  1  input VC holds a head-of-queue flit.
- req_port [NUM_PORTS][NUM_VCS]  in  3  absolute destination output port.
- req_vc [NUM_PORTS][NUM_VCS]  in  VC_ID_BITS  destination output VC.
- credit_in [NUM_PORTS][NUM_VCS]  in  1  one credit returned for output port p, VC v.
- grant [NUM_PORTS][NUM_VCS]  out  1  registered; the flit presented by input VC was taken.
- out_valid [NUM_PORTS][NUM_VCS]  out  1  registered; crossbar lane p,v carries a flit this cycle.
- p_sel [NUM_PORTS][NUM_VCS]  out  2  relative source port for lane p,v.
- vc_sel [NUM_PORTS][NUM_VCS]  out  VC_ID_BITS  source input VC for lane p,v.
- credit_err  out  1  sticky; a credit was returned to a full counter.

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: grant, out_valid, p_sel, vc_sel, credit_err = 0; credit counters = CREDIT_DEPTH; round-robin pointers = 0.
- Reset asserted mid-operation discards all pending state immediately.
- Candidate index: k = ip*NUM_VCS + iv, with N = NUM_PORTS*NUM_VCS candidates.
- Eligibility of input (ip,iv) for lane (p,v), all required:
  - req_valid = 1;
  - req_port = p and req_vc = v;
  - req_port != ip (a self-port request is ignored, never granted);
  - credit[p][v] > 0;
  - grant[ip][iv] not currently asserted.
- Masking: an input VC is never granted on two consecutive cycles, because its req_valid in the grant cycle still shows the consumed flit.
- Arbitration: per lane, search from ptr[p][v] upward modulo N; the first eligible candidate wins. On a win, ptr is set to winner+1 mod N. With no winner, ptr holds.
- Latency: requests sampled in cycle t; grant, out_valid, p_sel and vc_sel are visible in cycle t+1 and held exactly one cycle (all are pulses).
- The input VC must pop its flit on the clk edge that ends the grant cycle. The crossbar reads inport during that cycle.
- Relative encoding: p_sel = ip if ip < p, else ip-1. vc_sel = iv.
- When out_valid = 0, p_sel and vc_sel are 0.
- Each input requests only one lane, so no input-side conflict exists. Different lanes are independent and may all grant in the same cycle.
- Credit counter per lane, updated at the same edge that registers the grant:
  - grant only: -1;
  - credit_in only: +1;
  - both: unchanged;
  - credit_in while the counter = CREDIT_DEPTH and no grant: counter holds, credit_err is set to 1 and stays 1 until reset.
- A counter never underflows: a lane at 0 has no eligible candidates.
- The credit_in used for eligibility is the registered counter value. A credit arriving in cycle t enables a grant decided in cycle t+1.

Test Plan:
- Single grant: after reset, input (0,1) requests port 2 VC 3 for one cycle -> next cycle grant[0][1]=1, out_valid[2][3]=1, p_sel[2][3]=0, vc_sel[2][3]=1; the cycle after, all outputs are 0 and credit[2][3]=3.
- Relative encoding: input (4,0) requests port 1 VC 0 -> p_sel[1][0]=3. Input (1,2) requests port 3 VC 0 -> p_sel[3][0]=1, vc_sel[3][0]=2.
- Round-robin and masking: inputs (0,0) and (3,2) hold requests to (2,1), with credit_in pulsed after every grant -> grants alternate (0,0),(3,2),(0,0),...; out_valid[2][1] is 1 every cycle; neither input is granted twice in a row.
- Credit exhaustion: input (1,0) requests (4,2) continuously, no credit_in -> exactly 4 grants on alternate cycles, then none. One credit_in[4][2] pulse -> exactly one further grant, two cycles later.
- Credit corner cases: credit_in[4][2] in the same cycle as the grant decision -> counter unchanged. credit_in to a full counter -> credit_err=1 and stays 1.
- Illegal request and reset: input (2,0) requests port 2 -> never granted. Assert rst_n=0 while grants are flowing -> all outputs are 0 immediately; after release, counters=4 and ptr=0 (verify with scenario 1).
